rtc_clock_param: RTL and testbench
==================================

Name: rtc_clock_param

Overview:
- Parametrised BCD real-time clock for the Basys3 display designs; next generation of the fixed 100 MHz 24 h HH:MM counter.
- Adds the following over that counter:
  - configurable clock frequency;
  - visible seconds;
  - run/pause control;
  - time-set handshake with range checking;
  - runtime 12/24 h display mode;
  - single alarm with match pulse.
- Feeds the 7-segment mux and the FSM controller directly.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency. One second equals CLK_HZ cycles. Must be ≥ 2.
- PRESC_W, $clog2(CLK_HZ): prescaler width (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- run  in  1  1 = time advances; 0 = prescaler and time frozen
- mode_12h  in  1  output format: 0 = 24 h, 1 = 12 h
- set_valid  in  1  one-cycle load request
- set_hh_d, set_hh_u, set_mm_d, set_mm_u, set_ss_d, set_ss_u  in  4 each  BCD time to load (always 24 h)
- alarm_en  in  1  alarm enable
- alarm_hh_d, alarm_hh_u, alarm_mm_d, alarm_mm_u  in  4 each  BCD alarm time (24 h)
- hora_d, hora_u, min_d, min_u, seg_d, seg_u  out  4 each  displayed time, BCD
- pm  out  1  PM flag; valid only when mode_12h = 1, else 0
- sec_tick  out  1  one-cycle pulse on each second advance
- set_err  out  1  one-cycle pulse on a rejected set
- alarm_hit  out  1  one-cycle pulse on alarm match

Behaviour:
- Reset (async, active-high):
  - time = 00:00:00, prescaler = 0.
  - All pulse outputs 0. pm = 0.
  - hora = 00 in 24 h mode, 12 in 12 h mode.
- Internal time is always stored as 24 h BCD registers: hh 00–23, mm 00–59, ss 00–59.
- Prescaler:
  - Counts only while run = 1.
  - At CLK_HZ-1 it wraps to 0 and a tick occurs at that edge.
  - run = 0 holds the prescaler value, so there is no phase loss on resume.
- Tick increment chain:
  - ss_u 9→0 carries into ss_d; ss_d 5→0 carries into mm.
  - mm is handled the same way.
  - hh: u 9→0 carries into d; 23 wraps to 00.
  - All updates happen in the same edge. The new value is visible the cycle after the tick edge.
- sec_tick:
  - Registered; high for exactly the first cycle the new time is visible.
  - Exactly one pulse per CLK_HZ running cycles.
- Set handshake:
  - set_valid is sampled at the clock edge. The load is legal when every digit ≤ 9, hh ≤ 23, mm_d ≤ 5 and ss_d ≤ 5.
  - Legal load:
    - Time loads at that edge and the prescaler clears to 0.
    - Set has priority over a simultaneous tick; that tick is dropped and sec_tick is not pulsed.
    - The loaded time is visible next cycle.
  - Illegal load:
    - Time and prescaler are unchanged, and a simultaneous tick still applies.
    - set_err pulses for one cycle, the cycle after the request.
  - set_valid is accepted even while run = 0.
- Alarm:
  - Triggers on a tick-caused transition into hh:mm:00 equal to the alarm registers while alarm_en = 1.
  - alarm_hit pulses in the same cycle as that sec_tick.
  - A set landing exactly on the alarm time does not fire.
  - Illegal alarm values simply never match.
- 12 h output (combinational from the stored time, no added latency):
  - 00 → 12, pm = 0
  - 01–11 → unchanged, pm = 0
  - 12 → 12, pm = 1
  - 13–23 → hh−12, pm = 1
  - Minutes and seconds are unaffected.
  - Toggling mode_12h changes the outputs immediately and has no effect on the stored time.
- Reset mid-second: the prescaler restarts from 0, and the first tick arrives CLK_HZ cycles after reset deassertion with run = 1.

Decomposition:
- Package rtc_pkg contains:
  - constants SEC_MAX_D = 5, MIN_MAX_D = 5, HR_MAX_D = 2, HR_WRAP_U = 3, BCD_MAX = 9;
  - typedef bcd_t (logic [3:0]);
  - typedef struct bcd_time_t {hh_d, hh_u, mm_d, mm_u, ss_d, ss_u};
  - function time_legal(bcd_time_t).
- Sub-module hour_fmt_12h: pure combinational converter from 24 h BCD hour to 12 h BCD hour plus pm.
- The prescaler, increment chain, set logic and alarm compare stay in the top level.

Test Plan:
- CLK_HZ = 10, run = 1, reset released → first sec_tick after 10 cycles, seg_u = 1; after 600 cycles the outputs read 00:01:00.
- Set 23:59:58 legally, run 20 cycles → 00:00:00 visible with sec_tick. In 12 h mode this reads 12:00:00 pm = 0.
- Set hh = 24, and separately mm_d = 6 → set_err single pulse the next cycle; time unchanged. A tick coinciding with the rejected set still advances the time.
- run = 0 for 37 cycles midway through a second → no tick; the tick arrives exactly after the remaining prescaler count once run = 1 again.
- Alarm 07:30 enabled, set 07:29:59, 10 cycles → alarm_hit and sec_tick coincide once. Set 07:30:00 directly → no alarm_hit.
- 12 h sweep: set 12:00:00 → 12 pm = 1; set 13:05:00 → 01 pm = 1. Assert reset mid-second → outputs 00:00:00 asynchronously and all pulses 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared BCD time types, digit limits and the legality check used by the RTC.
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_MAX_D = 4'd5;
  localparam bcd_t MIN_MAX_D = 4'd5;
  localparam bcd_t HR_MAX_D  = 4'd2;
  localparam bcd_t HR_WRAP_U = 4'd3;
  localparam bcd_t BCD_MAX   = 4'd9;

  typedef struct packed {
    bcd_t hh_d;
    bcd_t hh_u;
    bcd_t mm_d;
    bcd_t mm_u;
    bcd_t ss_d;
    bcd_t ss_u;
  } bcd_time_t;

  function automatic logic time_legal(input bcd_time_t t);
    logic digits_ok;
    logic hh_ok;
    digits_ok = (t.hh_d <= BCD_MAX) && (t.hh_u <= BCD_MAX) && (t.mm_d <= BCD_MAX) &&
                (t.mm_u <= BCD_MAX) && (t.ss_d <= BCD_MAX) && (t.ss_u <= BCD_MAX);
    hh_ok = (t.hh_d < HR_MAX_D) || ((t.hh_d == HR_MAX_D) && (t.hh_u <= HR_WRAP_U));
    return digits_ok && hh_ok && (t.mm_d <= MIN_MAX_D) && (t.ss_d <= SEC_MAX_D);
  endfunction

endpackage

// File: rtl/hour_fmt_12h.sv
// Combinational 24 h BCD hour to 12 h BCD hour converter with PM flag.
module hour_fmt_12h
  import rtc_pkg::*;
(
  input  bcd_t hh_d,
  input  bcd_t hh_u,
  output bcd_t h12_d,
  output bcd_t h12_u,
  output logic pm
);

  logic [4:0] hh_bin;
  logic [4:0] h12_bin;

  always_comb begin
    hh_bin = 5'(hh_d) * 5'd10 + 5'(hh_u);
    pm     = (hh_bin >= 5'd12);
    if (hh_bin == 5'd0) begin
      h12_bin = 5'd12;
    end else if (hh_bin > 5'd12) begin
      h12_bin = hh_bin - 5'd12;
    end else begin
      h12_bin = hh_bin;
    end
    h12_d = (h12_bin >= 5'd10) ? 4'd1 : 4'd0;
    h12_u = (h12_bin >= 5'd10) ? 4'(h12_bin - 5'd10) : h12_bin[3:0];
  end

endmodule

// File: rtl/rtc_clock_param.sv
// Parametrised BCD real-time clock: prescaler, HH:MM:SS chain, time set, alarm, 12/24 h view.
module rtc_clock_param
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned PRESC_W = $clog2(CLK_HZ)
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic mode_12h,
  input  logic set_valid,
  input  bcd_t set_hh_d,
  input  bcd_t set_hh_u,
  input  bcd_t set_mm_d,
  input  bcd_t set_mm_u,
  input  bcd_t set_ss_d,
  input  bcd_t set_ss_u,
  input  logic alarm_en,
  input  bcd_t alarm_hh_d,
  input  bcd_t alarm_hh_u,
  input  bcd_t alarm_mm_d,
  input  bcd_t alarm_mm_u,
  output bcd_t hora_d,
  output bcd_t hora_u,
  output bcd_t min_d,
  output bcd_t min_u,
  output bcd_t seg_d,
  output bcd_t seg_u,
  output logic pm,
  output logic sec_tick,
  output logic set_err,
  output logic alarm_hit
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  bcd_time_t          time_q, time_d, time_inc, set_time;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick, set_ok, alarm_match;
  logic               sec_tick_q, set_err_q, alarm_hit_q;
  bcd_t               h12_d, h12_u;
  logic               h12_pm;

  assign set_time = '{hh_d: set_hh_d, hh_u: set_hh_u, mm_d: set_mm_d,
                      mm_u: set_mm_u, ss_d: set_ss_d, ss_u: set_ss_u};

  assign tick   = run && (presc_q == PRESC_LAST);
  assign set_ok = set_valid && time_legal(set_time);

  // Full ripple of the BCD chain, evaluated every cycle and used only on a tick.
  always_comb begin
    time_inc = time_q;
    if (time_q.ss_u != BCD_MAX) begin
      time_inc.ss_u = time_q.ss_u + 4'd1;
    end else begin
      time_inc.ss_u = '0;
      if (time_q.ss_d != SEC_MAX_D) begin
        time_inc.ss_d = time_q.ss_d + 4'd1;
      end else begin
        time_inc.ss_d = '0;
        if (time_q.mm_u != BCD_MAX) begin
          time_inc.mm_u = time_q.mm_u + 4'd1;
        end else begin
          time_inc.mm_u = '0;
          if (time_q.mm_d != MIN_MAX_D) begin
            time_inc.mm_d = time_q.mm_d + 4'd1;
          end else begin
            time_inc.mm_d = '0;
            if ((time_q.hh_d == HR_MAX_D) && (time_q.hh_u == HR_WRAP_U)) begin
              time_inc.hh_d = '0;
              time_inc.hh_u = '0;
            end else if (time_q.hh_u == BCD_MAX) begin
              time_inc.hh_u = '0;
              time_inc.hh_d = time_q.hh_d + 4'd1;
            end else begin
              time_inc.hh_u = time_q.hh_u + 4'd1;
            end
          end
        end
      end
    end
  end

  assign alarm_match = alarm_en &&
                       (time_inc.hh_d == alarm_hh_d) && (time_inc.hh_u == alarm_hh_u) &&
                       (time_inc.mm_d == alarm_mm_d) && (time_inc.mm_u == alarm_mm_u) &&
                       (time_inc.ss_d == '0) && (time_inc.ss_u == '0);

  // A legal set wins over a coincident tick; an illegal one leaves the tick alone.
  always_comb begin
    time_d  = time_q;
    presc_d = presc_q;
    if (set_ok) begin
      time_d  = set_time;
      presc_d = '0;
    end else if (run) begin
      if (tick) begin
        time_d  = time_inc;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q      <= '0;
      presc_q     <= '0;
      sec_tick_q  <= 1'b0;
      set_err_q   <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      time_q      <= time_d;
      presc_q     <= presc_d;
      sec_tick_q  <= tick && !set_ok;
      set_err_q   <= set_valid && !set_ok;
      alarm_hit_q <= tick && !set_ok && alarm_match;
    end
  end

  hour_fmt_12h u_hour_fmt (
    .hh_d  (time_q.hh_d),
    .hh_u  (time_q.hh_u),
    .h12_d (h12_d),
    .h12_u (h12_u),
    .pm    (h12_pm)
  );

  assign hora_d    = mode_12h ? h12_d : time_q.hh_d;
  assign hora_u    = mode_12h ? h12_u : time_q.hh_u;
  assign min_d     = time_q.mm_d;
  assign min_u     = time_q.mm_u;
  assign seg_d     = time_q.ss_d;
  assign seg_u     = time_q.ss_u;
  assign pm        = mode_12h && h12_pm;
  assign sec_tick  = sec_tick_q;
  assign set_err   = set_err_q;
  assign alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_rtc_clock_param.sv
// Bench for rtc_clock_param: seconds-of-day model checked every cycle, plus directed literals.
module tb_rtc_clock_param;

  localparam int unsigned CLK_HZ = 10;
  localparam int DAY = 86400;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0, mode_12h = 1'b0, set_valid = 1'b0, alarm_en = 1'b0;
  logic [3:0] set_hh_d = '0, set_hh_u = '0, set_mm_d = '0, set_mm_u = '0;
  logic [3:0] set_ss_d = '0, set_ss_u = '0;
  logic [3:0] alarm_hh_d = '0, alarm_hh_u = '0, alarm_mm_d = '0, alarm_mm_u = '0;
  logic [3:0] hora_d, hora_u, min_d, min_u, seg_d, seg_u;
  logic pm, sec_tick, set_err, alarm_hit;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rtc_clock_param #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h), .set_valid(set_valid),
    .set_hh_d(set_hh_d), .set_hh_u(set_hh_u), .set_mm_d(set_mm_d), .set_mm_u(set_mm_u),
    .set_ss_d(set_ss_d), .set_ss_u(set_ss_u), .alarm_en(alarm_en),
    .alarm_hh_d(alarm_hh_d), .alarm_hh_u(alarm_hh_u), .alarm_mm_d(alarm_mm_d),
    .alarm_mm_u(alarm_mm_u), .hora_d(hora_d), .hora_u(hora_u), .min_d(min_d), .min_u(min_u),
    .seg_d(seg_d), .seg_u(seg_u), .pm(pm), .sec_tick(sec_tick), .set_err(set_err),
    .alarm_hit(alarm_hit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int val2(input logic [3:0] d, input logic [3:0] u);
    return int'(d) * 10 + int'(u);
  endfunction

  function automatic logic [23:0] disp(input int s, input bit m12);
    int hh, mm, ss, h;
    hh = s / 3600;
    mm = (s / 60) % 60;
    ss = s % 60;
    h = m12 ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Model: time as seconds of day, prescaler as plain count of running cycles.
  int m_secs, m_presc, m_set_secs, m_alarm_secs;
  logic m_tick_q, m_err_q, m_hit_q;
  bit m_tick, m_set_legal, m_set_ok, m_alarm_legal;

  always_comb begin
    m_tick = run && (m_presc == int'(CLK_HZ) - 1);
    m_set_secs = val2(set_hh_d, set_hh_u) * 3600 + val2(set_mm_d, set_mm_u) * 60 +
                 val2(set_ss_d, set_ss_u);
    m_set_legal = (set_hh_d <= 9) && (set_hh_u <= 9) && (set_mm_d <= 9) && (set_mm_u <= 9) &&
                  (set_ss_d <= 9) && (set_ss_u <= 9) && (val2(set_hh_d, set_hh_u) < 24) &&
                  (val2(set_mm_d, set_mm_u) < 60) && (val2(set_ss_d, set_ss_u) < 60);
    m_set_ok = set_valid && m_set_legal;
    m_alarm_secs = val2(alarm_hh_d, alarm_hh_u) * 3600 + val2(alarm_mm_d, alarm_mm_u) * 60;
    m_alarm_legal = (alarm_hh_d <= 9) && (alarm_hh_u <= 9) && (alarm_mm_d <= 9) &&
                    (alarm_mm_u <= 9) && (val2(alarm_hh_d, alarm_hh_u) < 24) &&
                    (val2(alarm_mm_d, alarm_mm_u) < 60);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_secs <= 0;
      m_presc <= 0;
      m_tick_q <= 1'b0;
      m_err_q <= 1'b0;
      m_hit_q <= 1'b0;
    end else begin
      m_err_q <= set_valid && !m_set_legal;
      m_tick_q <= m_tick && !m_set_ok;
      m_hit_q <= m_tick && !m_set_ok && alarm_en && m_alarm_legal &&
                 (((m_secs + 1) % DAY) == m_alarm_secs);
      if (m_set_ok) begin
        m_secs <= m_set_secs;
        m_presc <= 0;
      end else if (run) begin
        if (m_tick) begin
          m_secs <= (m_secs + 1) % DAY;
          m_presc <= 0;
        end else begin
          m_presc <= m_presc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("time", 32'({hora_d, hora_u, min_d, min_u, seg_d, seg_u}), 32'(disp(m_secs, mode_12h)));
      check("pm", 32'(pm), 32'(mode_12h && (m_secs >= 43200)));
      check("pulses", 32'({sec_tick, set_err, alarm_hit}), 32'({m_tick_q, m_err_q, m_hit_q}));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_set(input int hh, input int mm, input int ss);
    set_hh_d = 4'(hh / 10); set_hh_u = 4'(hh % 10);
    set_mm_d = 4'(mm / 10); set_mm_u = 4'(mm % 10);
    set_ss_d = 4'(ss / 10); set_ss_u = 4'(ss % 10);
    set_valid = 1'b1;
    step(1);
    set_valid = 1'b0;
  endtask

  task automatic edges_to_tick(input int limit, output int cnt);
    cnt = 0;
    for (int i = 1; i <= limit && cnt == 0; i++) begin
      step(1);
      if (sec_tick) cnt = i;
    end
  endtask

  function automatic logic [23:0] now_digits();
    return {hora_d, hora_u, min_d, min_u, seg_d, seg_u};
  endfunction

  initial begin
    int cnt, hits, am;
    run = 1'b1;
    mode_12h = 1'b1;
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    check("rst_hora_12h", 32'({hora_d, hora_u}), 32'h12);
    check("rst_pm", 32'(pm), 32'd0);
    check("rst_pulses", 32'({sec_tick, set_err, alarm_hit}), 32'd0);
    mode_12h = 1'b0;
    #1 check("rst_time_24h", 32'(now_digits()), 32'h000000);
    @(posedge clk);
    #1 reset = 1'b0;

    edges_to_tick(20, cnt);
    check("first_tick_cycles", 32'(cnt), 32'd10);
    check("first_tick_seg_u", 32'(seg_u), 32'd1);
    step(590);
    check("one_minute_time", 32'(now_digits()), 32'h000100);
    check("one_minute_tick", 32'(sec_tick), 32'd1);

    do_set(23, 59, 58);
    step(20);
    check("midnight_wrap", 32'(now_digits()), 32'h000000);
    check("midnight_tick", 32'(sec_tick), 32'd1);
    mode_12h = 1'b1;
    #1 check("midnight_12h", 32'({hora_d, hora_u, pm}), 32'({8'h12, 1'b0}));
    mode_12h = 1'b0;

    do_set(24, 0, 0);
    check("bad_hh_err", 32'({set_err, sec_tick}), 32'b10);
    check("bad_hh_time", 32'(now_digits()), 32'h000000);
    step(1);
    check("bad_hh_err_single", 32'(set_err), 32'd0);
    step(7);
    do_set(0, 65, 0);
    check("bad_mm_err_with_tick", 32'({set_err, sec_tick}), 32'b11);
    check("bad_mm_time_advanced", 32'(now_digits()), 32'h000001);

    step(4);
    run = 1'b0;
    hits = 0;
    for (int i = 0; i < 37; i++) begin
      step(1);
      if (sec_tick) hits++;
    end
    check("pause_no_tick", 32'(hits), 32'd0);
    run = 1'b1;
    edges_to_tick(20, cnt);
    check("resume_tick_cycles", 32'(cnt), 32'd6);
    check("resume_seg_u", 32'(seg_u), 32'd2);

    alarm_hh_d = 4'd0; alarm_hh_u = 4'd7; alarm_mm_d = 4'd3; alarm_mm_u = 4'd0;
    alarm_en = 1'b1;
    do_set(7, 29, 59);
    hits = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (alarm_hit) hits++;
      if (i == 10) check("alarm_with_tick", 32'({sec_tick, alarm_hit}), 32'b11);
    end
    check("alarm_hit_count", 32'(hits), 32'd1);
    do_set(7, 30, 0);
    check("alarm_not_on_set", 32'(alarm_hit), 32'd0);
    alarm_en = 1'b0;

    mode_12h = 1'b1;
    do_set(12, 0, 0);
    check("noon_12h", 32'({hora_d, hora_u, pm}), 32'({8'h12, 1'b1}));
    do_set(13, 5, 0);
    check("pm_13h", 32'({hora_d, hora_u, min_d, min_u, pm}), 32'({16'h0105, 1'b1}));
    step(3);
    mode_12h = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_rst_time", 32'(now_digits()), 32'h000000);
    check("async_rst_pulses", 32'({sec_tick, set_err, alarm_hit, pm}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    edges_to_tick(20, cnt);
    check("post_rst_tick_cycles", 32'(cnt), 32'd10);

    for (int it = 0; it < 3000; it++) begin
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
      set_valid = ($urandom_range(0, 39) == 0);
      if (set_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          am = $urandom_range(0, 23);
          set_hh_d = 4'(am / 10); set_hh_u = 4'(am % 10);
          am = $urandom_range(0, 59);
          set_mm_d = 4'(am / 10); set_mm_u = 4'(am % 10);
          am = $urandom_range(50, 59);
          set_ss_d = 4'(am / 10); set_ss_u = 4'(am % 10);
        end else begin
          set_hh_d = 4'($urandom_range(0, 15)); set_hh_u = 4'($urandom_range(0, 15));
          set_mm_d = 4'($urandom_range(0, 15)); set_mm_u = 4'($urandom_range(0, 15));
          set_ss_d = 4'($urandom_range(0, 15)); set_ss_u = 4'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 29) == 0) begin
        alarm_en = ($urandom_range(0, 3) != 0);
        am = (m_secs / 60 + 1) % 1440;
        alarm_hh_d = 4'(am / 600); alarm_hh_u = 4'((am / 60) % 10);
        alarm_mm_d = 4'((am % 60) / 10); alarm_mm_u = 4'(am % 10);
        if ($urandom_range(0, 4) == 0) alarm_mm_d = 4'($urandom_range(6, 15));
      end
      step(1);
    end
    set_valid = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
